pipelined_addsub: RTL

//  Parametrised WIDTH-bit adder/subtractor. The carry chain is cut into STAGES segments of SEG bits,

---
 rtl/addsub_pkg.sv | 19 +
 rtl/addsub_segment.sv | 31 +++
 rtl/pipelined_addsub.sv | 127 ++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor: opcode encoding and
// the flag bundle produced alongside each result.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int FLAG_COUT = 0;
  localparam int FLAG_OVF  = 1;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_W    = 3;

  typedef struct packed {
    logic zero;
    logic ovf;
    logic cout;
  } addsub_flags_t;

endpackage

// File: rtl/addsub_segment.sv
// Combinational SEG-bit ripple slice; also exposes the carry into its top bit
// so the parent can form two's-complement overflow on the last slice.
module addsub_segment
  import addsub_pkg::*;
#(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb_in
);

  logic [SEG:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign co       = c[SEG];
  assign c_msb_in = c[SEG-1];

endmodule

// File: rtl/pipelined_addsub.sv
// WIDTH-bit adder/subtractor with the carry chain cut into STAGES registered
// slices, behind a valid/ready handshake with a single global enable.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;

  typedef logic [WIDTH-1:0] word_t;

  if (WIDTH % SEG != 0) begin : gen_seg_check
    $error("pipelined_addsub: WIDTH must be a multiple of SEG");
  end

  logic          en;

  // Stage registers. Operands are stored pre-shifted so the next slice to be
  // added always sits in bits [SEG-1:0]; finished slices enter the sum from
  // the top and move down, landing in place after the last stage.
  logic          st_v [STAGES];
  logic          st_c [STAGES];
  word_t         st_a [STAGES];
  word_t         st_b [STAGES];
  word_t         st_s [STAGES];

  logic          in_v  [STAGES];
  logic          in_c  [STAGES];
  word_t         in_a  [STAGES];
  word_t         in_b  [STAGES];
  word_t         in_s  [STAGES];
  word_t         nxt_s [STAGES];

  logic [SEG-1:0] seg_s  [STAGES];
  logic           seg_co [STAGES];
  logic           seg_cm [STAGES];

  addsub_flags_t flags_d;
  addsub_flags_t flags_q;

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = st_v[LAST];

  genvar k;
  for (k = 0; k < STAGES; k++) begin : gen_stage
    if (k == 0) begin : gen_head
      assign in_v[0] = in_valid;
      assign in_a[0] = a;
      assign in_b[0] = (op == OP_SUB) ? ~b : b;
      assign in_c[0] = cin;
      assign in_s[0] = '0;
    end else begin : gen_link
      assign in_v[k] = st_v[k-1];
      assign in_a[k] = st_a[k-1];
      assign in_b[k] = st_b[k-1];
      assign in_c[k] = st_c[k-1];
      assign in_s[k] = st_s[k-1];
    end

    addsub_segment #(
      .SEG (SEG)
    ) u_seg (
      .a        (in_a[k][SEG-1:0]),
      .b        (in_b[k][SEG-1:0]),
      .ci       (in_c[k]),
      .s        (seg_s[k]),
      .co       (seg_co[k]),
      .c_msb_in (seg_cm[k])
    );

    assign nxt_s[k] = (in_s[k] >> SEG) | (word_t'(seg_s[k]) << (WIDTH - SEG));
  end

  always_comb begin
    flags_d      = '0;
    flags_d.cout = seg_co[LAST];
    flags_d.ovf  = seg_co[LAST] ^ seg_cm[LAST];
    flags_d.zero = (nxt_s[LAST] == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < STAGES; i++) begin
        st_v[i] <= 1'b0;
        st_c[i] <= 1'b0;
        st_a[i] <= '0;
        st_b[i] <= '0;
        st_s[i] <= '0;
      end
      flags_q <= '0;
    end else if (en) begin
      for (int i = 0; i < STAGES; i++) begin
        st_v[i] <= in_v[i];
        st_c[i] <= seg_co[i];
        st_a[i] <= in_a[i] >> SEG;
        st_b[i] <= in_b[i] >> SEG;
        st_s[i] <= nxt_s[i];
      end
      flags_q <= flags_d;
    end
  end

  assign sum  = st_s[LAST];
  assign cout = flags_q.cout;
  assign ovf  = flags_q.ovf;
  assign zero = flags_q.zero;

endmodule
